// File: rtl/axi_b_buffer_stat.sv
// rtl/axi_b_buffer_stat.sv - AXI B-channel ring buffer with fall-through, occupancy, almost-full and error statistics
module axi_b_buffer_stat #(
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned USER_WIDTH    = 6,
  parameter int unsigned BUFFER_DEPTH  = 8,
  parameter bit          FALL_THROUGH  = 1'b0,
  parameter int unsigned AF_THRESH     = BUFFER_DEPTH - 1,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             test_en_i,
  input  logic                             slave_valid_i,
  input  logic [1:0]                       slave_resp_i,
  input  logic [ID_WIDTH-1:0]              slave_id_i,
  input  logic [USER_WIDTH-1:0]            slave_user_i,
  output logic                             slave_ready_o,
  output logic                             master_valid_o,
  output logic [1:0]                       master_resp_o,
  output logic [ID_WIDTH-1:0]              master_id_o,
  output logic [USER_WIDTH-1:0]            master_user_o,
  input  logic                             master_ready_i,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0] count_o,
  output logic                             almost_full_o,
  output logic [ERR_CNT_WIDTH-1:0]         err_cnt_o,
  input  logic                             clr_err_i
);

  localparam int unsigned PTR_W  = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned DATA_W = ID_WIDTH + USER_WIDTH + 2;

  // Entry layout: {id, user, resp}
  logic [DATA_W-1:0] mem [BUFFER_DEPTH];

  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  logic [DATA_W-1:0]        head;

  logic empty;
  logic bypass;
  logic pass_through;
  logic in_xfer;
  logic out_xfer;
  logic push;
  logic pop;
  logic err_hit;

  // test_en_i has no functional effect; it is only kept for port compatibility.
  logic unused_test_en;
  assign unused_test_en = test_en_i;

  assign empty         = (count == '0);
  assign slave_ready_o = (count != CNT_W'(BUFFER_DEPTH));

  // Fall-through only applies to an empty buffer; held off during reset so outputs stay quiet.
  assign bypass       = FALL_THROUGH && empty && slave_valid_i && rst_ni;
  assign pass_through = bypass && master_ready_i;

  assign in_xfer  = slave_valid_i && slave_ready_o;
  assign out_xfer = master_valid_o && master_ready_i;

  // A passed-through beat never touches storage, so it neither pushes nor pops.
  assign push    = in_xfer && !pass_through;
  assign pop     = out_xfer && !pass_through;
  assign err_hit = out_xfer && master_resp_o[1];

  // Present the head entry, the bypassed input, or zeros when idle.
  always_comb begin
    master_valid_o = 1'b0;
    head           = '0;
    if (!empty) begin
      master_valid_o = 1'b1;
      head           = mem[rd_ptr];
    end else if (bypass) begin
      master_valid_o = 1'b1;
      head           = {slave_id_i, slave_user_i, slave_resp_i};
    end
  end

  assign {master_id_o, master_user_o, master_resp_o} = head;

  // Storage array is deliberately left unreset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {slave_id_i, slave_user_i, slave_resp_i};
    end
  end

  // Ring pointers wrap at BUFFER_DEPTH-1, which need not be a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy moves only when exactly one side touches storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (pop && !push) begin
      count <= count - CNT_W'(1);
    end
  end

  assign count_o       = count;
  assign almost_full_o = (count >= CNT_W'(AF_THRESH));

  // Saturating count of delivered SLVERR/DECERR; a coincident clear still records the new error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt <= '0;
    end else if (err_hit) begin
      if (clr_err_i) begin
        err_cnt <= ERR_CNT_WIDTH'(1);
      end else if (err_cnt != '1) begin
        err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
      end
    end else if (clr_err_i) begin
      err_cnt <= '0;
    end
  end

  assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_axi_b_buffer_stat.sv
// tb/tb_axi_b_buffer_stat.sv - directed self-checking bench for axi_b_buffer_stat
module tb_axi_b_buffer_stat;

  logic clk;
  logic rst_n;
  logic test_en;

  int n_cmp;
  int n_err;

  // u_a: DEPTH 8, registered, 2-bit error counter
  logic       a_valid, a_sready, a_mvalid, a_mready, a_af, a_clr;
  logic [1:0] a_resp, a_mresp, a_err;
  logic [3:0] a_id, a_mid, a_count;
  logic [5:0] a_user, a_muser;

  // u_b: DEPTH 5, fall-through
  logic        b_valid, b_sready, b_mvalid, b_mready, b_af, b_clr;
  logic [1:0]  b_resp, b_mresp;
  logic [3:0]  b_id, b_mid;
  logic [5:0]  b_user, b_muser;
  logic [2:0]  b_count;
  logic [15:0] b_err;

  // u_c: DEPTH 1, registered
  logic        c_valid, c_sready, c_mvalid, c_mready, c_af, c_clr;
  logic [1:0]  c_resp, c_mresp;
  logic [3:0]  c_id, c_mid;
  logic [5:0]  c_user, c_muser;
  logic [0:0]  c_count;
  logic [15:0] c_err;

  axi_b_buffer_stat #(.ID_WIDTH(4), .USER_WIDTH(6), .BUFFER_DEPTH(8), .FALL_THROUGH(1'b0),
                      .AF_THRESH(7), .ERR_CNT_WIDTH(2)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .slave_valid_i(a_valid), .slave_resp_i(a_resp), .slave_id_i(a_id), .slave_user_i(a_user),
    .slave_ready_o(a_sready),
    .master_valid_o(a_mvalid), .master_resp_o(a_mresp), .master_id_o(a_mid), .master_user_o(a_muser),
    .master_ready_i(a_mready),
    .count_o(a_count), .almost_full_o(a_af), .err_cnt_o(a_err), .clr_err_i(a_clr)
  );

  axi_b_buffer_stat #(.ID_WIDTH(4), .USER_WIDTH(6), .BUFFER_DEPTH(5), .FALL_THROUGH(1'b1),
                      .AF_THRESH(4), .ERR_CNT_WIDTH(16)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .slave_valid_i(b_valid), .slave_resp_i(b_resp), .slave_id_i(b_id), .slave_user_i(b_user),
    .slave_ready_o(b_sready),
    .master_valid_o(b_mvalid), .master_resp_o(b_mresp), .master_id_o(b_mid), .master_user_o(b_muser),
    .master_ready_i(b_mready),
    .count_o(b_count), .almost_full_o(b_af), .err_cnt_o(b_err), .clr_err_i(b_clr)
  );

  axi_b_buffer_stat #(.ID_WIDTH(4), .USER_WIDTH(6), .BUFFER_DEPTH(1), .FALL_THROUGH(1'b0),
                      .AF_THRESH(1), .ERR_CNT_WIDTH(16)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .slave_valid_i(c_valid), .slave_resp_i(c_resp), .slave_id_i(c_id), .slave_user_i(c_user),
    .slave_ready_o(c_sready),
    .master_valid_o(c_mvalid), .master_resp_o(c_mresp), .master_id_o(c_mid), .master_user_o(c_muser),
    .master_ready_i(c_mready),
    .count_o(c_count), .almost_full_o(c_af), .err_cnt_o(c_err), .clr_err_i(c_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int err_exp [5];
  logic [1:0] resp_seq [5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_en = 1'b0;
    rst_n = 1'b0;
    a_valid = 0; a_resp = 0; a_id = 0; a_user = 0; a_mready = 0; a_clr = 0;
    b_valid = 0; b_resp = 0; b_id = 0; b_user = 0; b_mready = 0; b_clr = 0;
    c_valid = 0; c_resp = 0; c_id = 0; c_user = 0; c_mready = 0; c_clr = 0;
    resp_seq[0] = 2'd2; resp_seq[1] = 2'd3; resp_seq[2] = 2'd0; resp_seq[3] = 2'd2; resp_seq[4] = 2'd2;
    err_exp[0] = 1; err_exp[1] = 2; err_exp[2] = 2; err_exp[3] = 3; err_exp[4] = 3;

    #1;
    chk("rst_sready", 32'(a_sready), 1);
    chk("rst_mvalid", 32'(a_mvalid), 0);
    chk("rst_count", 32'(a_count), 0);
    chk("rst_af", 32'(a_af), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_mid", 32'(a_mid), 0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Fill DEPTH 8 with no downstream ready
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_id = 4'(i); a_user = 6'(i + 1); a_resp = 2'd0;
      #1;
      chk("fill_sready", 32'(a_sready), 1);
      cyc();
      chk("fill_count", 32'(a_count), 32'(i + 1));
      chk("fill_af", 32'(a_af), 32'(i + 1 >= 7));
    end
    a_id = 4'hF;
    cyc();
    a_valid = 1'b0;
    chk("full_sready", 32'(a_sready), 0);
    chk("full_no_write", 32'(a_count), 8);

    // Drain in order
    a_mready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_mvalid", 32'(a_mvalid), 1);
      chk("drain_mid", 32'(a_mid), 32'(i));
      chk("drain_muser", 32'(a_muser), 32'(i + 1));
      cyc();
    end
    chk("drained_mvalid", 32'(a_mvalid), 0);
    chk("drained_mid", 32'(a_mid), 0);
    chk("drained_count", 32'(a_count), 0);

    // Error counter saturation at 2 bits
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1; a_resp = resp_seq[i]; a_id = 4'(i);
      cyc();
      a_valid = 1'b0;
      #1;
      chk("err_latency_mvalid", 32'(a_mvalid), 1);
      chk("err_mresp", 32'(a_mresp), 32'(resp_seq[i]));
      cyc();
      chk("err_cnt", 32'(a_err), 32'(err_exp[i]));
    end
    a_valid = 1'b1; a_resp = 2'd3;
    cyc();
    a_valid = 1'b0; a_clr = 1'b1;
    cyc();
    a_clr = 1'b0;
    chk("err_clr_coincident", 32'(a_err), 1);
    a_clr = 1'b1;
    cyc();
    a_clr = 1'b0;
    chk("err_clr_only", 32'(a_err), 0);

    // Async reset with 4 stored entries
    a_mready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      a_valid = 1'b1; a_id = 4'(i); a_resp = 2'd0;
      cyc();
    end
    a_valid = 1'b0;
    chk("pre_rst_count", 32'(a_count), 4);
    chk("pre_rst_mvalid", 32'(a_mvalid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(a_count), 0);
    chk("async_rst_mvalid", 32'(a_mvalid), 0);
    chk("async_rst_mid", 32'(a_mid), 0);
    chk("async_rst_sready", 32'(a_sready), 1);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_no_stale", 32'(a_mvalid), 0);
    a_valid = 1'b1; a_id = 4'h9;
    cyc();
    a_valid = 1'b0;
    chk("post_rst_mid", 32'(a_mid), 9);
    a_mready = 1'b1;
    cyc();
    chk("post_rst_drained", 32'(a_mvalid), 0);

    // Fall-through, empty, downstream ready
    b_valid = 1'b1; b_id = 4'hA; b_resp = 2'd0; b_mready = 1'b1;
    #1;
    chk("ft_mvalid", 32'(b_mvalid), 1);
    chk("ft_mid", 32'(b_mid), 32'hA);
    cyc();
    chk("ft_count", 32'(b_count), 0);
    b_id = 4'hB; b_mready = 1'b0;
    #1;
    chk("ft_stall_mid", 32'(b_mid), 32'hB);
    cyc();
    b_valid = 1'b0;
    chk("ft_stall_count", 32'(b_count), 1);
    chk("ft_stall_mvalid", 32'(b_mvalid), 1);
    chk("ft_stall_held", 32'(b_mid), 32'hB);
    b_mready = 1'b1;
    cyc();
    chk("ft_popped", 32'(b_count), 0);

    // Steady push/pop at count 3 across pointer wrap
    b_mready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1; b_id = 4'(i);
      cyc();
    end
    chk("pp_fill_count", 32'(b_count), 3);
    b_mready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      b_valid = 1'b1; b_id = 4'(k + 3);
      #1;
      chk("pp_order", 32'(b_mid), 32'(k & 15));
      cyc();
    end
    b_valid = 1'b0;
    chk("pp_count", 32'(b_count), 3);
    chk("pp_next", 32'(b_mid), 4);
    cyc(); cyc(); cyc();
    chk("pp_drained", 32'(b_count), 0);

    // DEPTH 1 alternating throughput
    c_mready = 1'b1; c_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      c_id = 4'(k / 2);
      #1;
      chk("d1_sready", 32'(c_sready), 32'(k % 2 == 0));
      chk("d1_mvalid", 32'(c_mvalid), 32'(k % 2 == 1));
      chk("d1_mid", 32'(c_mid), (k % 2 == 1) ? 32'(k / 2) : 32'd0);
      cyc();
    end
    c_mready = 1'b0; c_id = 4'h7;
    cyc();
    c_id = 4'h3;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("d1_stall_mvalid", 32'(c_mvalid), 1);
      chk("d1_stall_mid", 32'(c_mid), 7);
      chk("d1_stall_sready", 32'(c_sready), 0);
      cyc();
    end
    c_valid = 1'b0; c_mready = 1'b1;
    cyc();
    chk("d1_drained", 32'(c_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
